controle_digitos_n: RTL and testbench

CONTROLE_DIGITOS_N -- requirements
Module: controle_digitos_n

---
 rtl/controle_digitos_n.sv | 106 ++++++++++
 tb/tb_controle_digitos_n.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/controle_digitos_n.sv
// controle_digitos_n: keypad digit collector.
// Shifts accepted digits into a product code (first digit ends in the MS slot),
// locks once NUM_DIGITOS digits are held, and releases on OK or cancel.
// Optional feature: define CONTROLE_DIGITOS_TIMEOUT_EN to abort an entry left
// idle for TIMEOUT_CICLOS cycles (pulses tempoEsgotado).
module controle_digitos_n #(
  parameter int NUM_DIGITOS    = 2,
  parameter int DIG_W          = 4,
  parameter int DIG_MAX        = 9,
  parameter int TIMEOUT_CICLOS = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [DIG_W-1:0]                 digito,
  input  logic                             OK,
  input  logic                             cancel,
  output logic [NUM_DIGITOS*DIG_W-1:0]     codigo,
  output logic [$clog2(NUM_DIGITOS+1)-1:0] nDigitos,
  output logic                             completo,
  output logic                             clear,
  output logic                             tempoEsgotado
);

  localparam int CODE_W = NUM_DIGITOS * DIG_W;
  localparam int CNT_W  = $clog2(NUM_DIGITOS + 1);
  localparam logic [DIG_W-1:0] DMAX   = DIG_W'(DIG_MAX);
  localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(NUM_DIGITOS - 1);

  typedef enum logic [1:0] {ESPERA, ENTRADA, BLOQUEADO} estado_t;

  estado_t estado;
  logic    aceito;
  logic    expira;
  logic    paraEspera;

`ifdef CONTROLE_DIGITOS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CICLOS);
  localparam logic [TO_W-1:0] TO_FIM = TO_W'(TIMEOUT_CICLOS - 1);
  logic [TO_W-1:0] ocioso;
`endif

  // Event decode: digit acceptance, idle expiry and the return-to-idle condition
  always_comb begin
    aceito = enable && (digito <= DMAX) && (estado != BLOQUEADO);
`ifdef CONTROLE_DIGITOS_TIMEOUT_EN
    expira = (estado == ENTRADA) && (ocioso == TO_FIM);
`else
    expira = 1'b0;
`endif
    // Priority cancel > accepted digit > timeout > OK
    paraEspera = cancel || (!aceito && (expira || ((estado == BLOQUEADO) && OK)));
  end

  // State machine with registered code, count and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado        <= ESPERA;
      codigo        <= '0;
      nDigitos      <= '0;
      clear         <= 1'b1;
      completo      <= 1'b0;
`ifdef CONTROLE_DIGITOS_TIMEOUT_EN
      ocioso        <= '0;
      tempoEsgotado <= 1'b0;
`endif
    end else begin
`ifdef CONTROLE_DIGITOS_TIMEOUT_EN
      tempoEsgotado <= !cancel && !aceito && expira;
`endif
      if (paraEspera) begin
        estado   <= ESPERA;
        codigo   <= '0;
        nDigitos <= '0;
        clear    <= 1'b1;
        completo <= 1'b0;
`ifdef CONTROLE_DIGITOS_TIMEOUT_EN
        ocioso   <= '0;
`endif
      end else if (aceito) begin
        codigo   <= (codigo << DIG_W) | CODE_W'(digito);
        nDigitos <= nDigitos + CNT_W'(1);
        clear    <= 1'b0;
`ifdef CONTROLE_DIGITOS_TIMEOUT_EN
        ocioso   <= '0;
`endif
        if (nDigitos == ULTIMO) begin
          estado   <= BLOQUEADO;
          completo <= 1'b1;
        end else begin
          estado   <= ENTRADA;
          completo <= 1'b0;
        end
      end else if (estado == ENTRADA) begin
`ifdef CONTROLE_DIGITOS_TIMEOUT_EN
        ocioso <= ocioso + TO_W'(1);
`endif
      end
    end
  end

`ifndef CONTROLE_DIGITOS_TIMEOUT_EN
  assign tempoEsgotado = 1'b0;
`endif

endmodule

// File: tb/tb_controle_digitos_n.sv
// Testbench for controle_digitos_n (NUM_DIGITOS=2, DIG_W=4, DIG_MAX=9,
// TIMEOUT_CICLOS=8). Expectations follow CONTROLE_DIGITOS_TIMEOUT_EN.
module tb_controle_digitos_n;

  localparam int N  = 2;
  localparam int T  = 8;
`ifdef CONTROLE_DIGITOS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic [3:0] digito;
  logic       OK;
  logic       cancel;
  logic [7:0] codigo;
  logic [1:0] nDigitos;
  logic       completo;
  logic       clear;
  logic       tempoEsgotado;

  int checks = 0;
  int errors = 0;

  controle_digitos_n #(
    .NUM_DIGITOS(N),
    .DIG_W(4),
    .DIG_MAX(9),
    .TIMEOUT_CICLOS(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .digito(digito),
    .OK(OK),
    .cancel(cancel),
    .codigo(codigo),
    .nDigitos(nDigitos),
    .completo(completo),
    .clear(clear),
    .tempoEsgotado(tempoEsgotado)
  );

  always #5 clk = ~clk;

  // Reference model: the held code is the list of accepted digits.
  int mDig[$];
  int mIdle;
  bit mPulse;

  function automatic int modelCode();
    int c = 0;
    foreach (mDig[i]) c = c * 16 + mDig[i];
    return c;
  endfunction

  task automatic modelReset();
    mDig.delete();
    mIdle  = 0;
    mPulse = 1'b0;
  endtask

  task automatic modelStep(input bit en, input int d, input bit ok, input bit can);
    mPulse = 1'b0;
    if (can) begin
      mDig.delete();
      mIdle = 0;
    end else if (en && d <= 9 && mDig.size() < N) begin
      mDig.push_back(d);
      mIdle = 0;
    end else if (mDig.size() > 0 && mDig.size() < N) begin
      if (TO_EN && mIdle == T - 1) begin
        mDig.delete();
        mIdle  = 0;
        mPulse = 1'b1;
      end else begin
        mIdle++;
      end
    end else if (mDig.size() == N && ok) begin
      mDig.delete();
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chkAll(input string tag, input int eCod, input int eN,
                        input bit eComp, input bit eClr, input bit eTo);
    chk({tag, ".codigo"},   int'(codigo),        eCod);
    chk({tag, ".nDigitos"}, int'(nDigitos),      eN);
    chk({tag, ".completo"}, int'(completo),      int'(eComp));
    chk({tag, ".clear"},    int'(clear),         int'(eClr));
    chk({tag, ".tempo"},    int'(tempoEsgotado), int'(eTo));
  endtask

  task automatic chkModel(input string tag);
    chkAll(tag, modelCode(), mDig.size(), mDig.size() == N, mDig.size() == 0, mPulse);
  endtask

  // One clock cycle: drive inputs, advance the model, sample #1 after the edge
  task automatic cycle(input bit en, input int d, input bit ok, input bit can);
    enable = en;
    digito = 4'(d);
    OK     = ok;
    cancel = can;
    @(posedge clk);
    #1;
    modelStep(en, d, ok, can);
    enable = 1'b0;
    OK     = 1'b0;
    cancel = 1'b0;
  endtask

  typedef struct {
    bit en; int d; bit ok; bit can;
    int eCod; int eN; bit eComp; bit eClr; bit eTo;
  } vec_t;

  vec_t tab[12];

  initial begin
    tab[0]  = '{1, 3,   0, 0, 'h03, 1, 0, 0, 0};
    tab[1]  = '{1, 7,   0, 0, 'h37, 2, 1, 0, 0};
    tab[2]  = '{1, 5,   0, 0, 'h37, 2, 1, 0, 0};  // locked: enable ignored
    tab[3]  = '{0, 0,   1, 0, 'h00, 0, 0, 1, 0};  // OK releases
    tab[4]  = '{1, 'hC, 0, 0, 'h00, 0, 0, 1, 0};  // invalid digit
    tab[5]  = '{1, 2,   0, 0, 'h02, 1, 0, 0, 0};
    tab[6]  = '{1, 'hF, 0, 0, 'h02, 1, 0, 0, 0};  // invalid in ENTRADA
    tab[7]  = '{1, 4,   0, 1, 'h00, 0, 0, 1, 0};  // cancel beats digit
    tab[8]  = '{0, 0,   1, 0, 'h00, 0, 0, 1, 0};  // OK ignored in ESPERA
    tab[9]  = '{1, 9,   0, 0, 'h09, 1, 0, 0, 0};
    tab[10] = '{1, 0,   0, 0, 'h90, 2, 1, 0, 0};
    tab[11] = '{0, 0,   0, 1, 'h00, 0, 0, 1, 0};  // cancel from BLOQUEADO

    rst = 1'b1; enable = 1'b0; digito = '0; OK = 1'b0; cancel = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    chkAll("reset", 0, 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table
    foreach (tab[i]) begin
      cycle(tab[i].en, tab[i].d, tab[i].ok, tab[i].can);
      chkAll($sformatf("tab%0d", i), tab[i].eCod, tab[i].eN, tab[i].eComp, tab[i].eClr, tab[i].eTo);
    end

    // Timeout after 8 idle cycles (or indefinite hold without the feature)
    cycle(1, 5, 0, 0);
    chkAll("to.dig", 'h05, 1, 0, 0, 0);
    for (int i = 1; i <= 7; i++) begin
      cycle(0, 0, 0, 0);
      chkAll($sformatf("to.idle%0d", i), 'h05, 1, 0, 0, 0);
    end
    cycle(0, 0, 0, 0);
    if (TO_EN) chkAll("to.fire", 0, 0, 0, 1, 1);
    else       chkAll("to.hold", 'h05, 1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    if (TO_EN) chkAll("to.after", 0, 0, 0, 1, 0);
    else       chkAll("to.after", 'h05, 1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chkAll("to.cancel", 0, 0, 0, 1, 0);

    // Digit accepted on the cycle the idle count reaches T-1
    cycle(1, 1, 0, 0);
    repeat (T - 1) cycle(0, 0, 0, 0);
    cycle(1, 2, 0, 0);
    chkAll("edge.accept", 'h12, 2, 1, 0, 0);
    cycle(0, 0, 0, 0);
    chkAll("edge.hold", 'h12, 2, 1, 0, 0);
    cycle(0, 0, 1, 0);
    chkAll("edge.ok", 0, 0, 0, 1, 0);

    // Asynchronous reset mid-entry, between edges
    cycle(1, 4, 0, 0);
    chkAll("arst.pre", 'h04, 1, 0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    chkAll("arst.now", 0, 0, 0, 1, 0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 6, 0, 0);
    chkAll("arst.first", 'h06, 1, 0, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      bit en, ok, can;
      int d;
      r   = $urandom_range(0, 99);
      en  = (r < 30);
      d   = $urandom_range(0, 15);
      ok  = ($urandom_range(0, 99) < 15);
      can = ($urandom_range(0, 99) < 3);
      cycle(en, d, ok, can);
      chkModel($sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
